umi_req_arbiter: RTL and testbench

- N-to-1 UMI request arbiter that shares one UMI request channel between N host-side requesters.
- The shared channel is typically the input of a umi_fifo_flex feeding a umi_mem_agent.
- Arbitration is message-atomic: once a requester wins, it holds the channel until its EOM transaction transfers.
- Supports round-robin or fixed-priority mode, per-requester masking, and a grant/status output for debug and tests.

---
 rtl/umi_req_arbiter.sv | 140 ++++++++++++++
 tb/tb_umi_req_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/umi_req_arbiter.sv
// N-to-1 UMI request arbiter with message-atomic locking.
// Round-robin or fixed-priority selection, per-requester masking, debug grant/locked outputs.
module umi_req_arbiter #(
  parameter int N  = 4,
  parameter int CW = 32,
  parameter int AW = 64,
  parameter int DW = 128
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic            mode,
  input  logic [N-1:0]    mask,
  input  logic [N-1:0]    umi_in_valid,
  input  logic [N*CW-1:0] umi_in_cmd,
  input  logic [N*AW-1:0] umi_in_dstaddr,
  input  logic [N*AW-1:0] umi_in_srcaddr,
  input  logic [N*DW-1:0] umi_in_data,
  output logic [N-1:0]    umi_in_ready,
  output logic            umi_out_valid,
  output logic [CW-1:0]   umi_out_cmd,
  output logic [AW-1:0]   umi_out_dstaddr,
  output logic [AW-1:0]   umi_out_srcaddr,
  output logic [DW-1:0]   umi_out_data,
  input  logic            umi_out_ready,
  output logic [N-1:0]    grant,
  output logic            locked
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;
  logic [IW-1:0] lock_idx_r;
  logic [IW-1:0] lock_idx_nxt_s;
  logic [IW-1:0] rr_ptr_r;
  logic [IW-1:0] rr_ptr_nxt_s;

  logic [N-1:0]  req_s;
  logic [IW-1:0] rr_idx_s;
  logic          rr_vld_s;
  logic [IW-1:0] fp_idx_s;
  logic          fp_vld_s;
  logic [IW-1:0] win_idx_s;
  logic          win_vld_s;
  logic          xfer_s;
  logic          eom_s;
  int            idx_s;

  // State register: lock tracking and round-robin pointer
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_r    <= IDLE;
      lock_idx_r <= '0;
      rr_ptr_r   <= '0;
    end else begin
      state_r    <= state_nxt_s;
      lock_idx_r <= lock_idx_nxt_s;
      rr_ptr_r   <= rr_ptr_nxt_s;
    end
  end

  // Winner selection; loops run high-to-low so the lowest-ranked hit is kept
  always_comb begin
    req_s    = umi_in_valid & ~mask;
    rr_idx_s = '0;
    rr_vld_s = 1'b0;
    fp_idx_s = '0;
    fp_vld_s = 1'b0;
    idx_s    = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx_s    = (int'(rr_ptr_r) + k) % N;
      rr_idx_s = req_s[idx_s] ? IW'(idx_s) : rr_idx_s;
      rr_vld_s = rr_vld_s | req_s[idx_s];
    end
    for (int i = N - 1; i >= 0; i--) begin
      fp_idx_s = req_s[i] ? IW'(i) : fp_idx_s;
      fp_vld_s = fp_vld_s | req_s[i];
    end
    if (state_r == LOCKED) begin
      win_idx_s = lock_idx_r;
      win_vld_s = 1'b1;
    end else if (mode) begin
      win_idx_s = fp_idx_s;
      win_vld_s = fp_vld_s;
    end else begin
      win_idx_s = rr_idx_s;
      win_vld_s = rr_vld_s;
    end
  end

  // Next-state: lock on non-EOM transfer, release on EOM transfer
  always_comb begin
    state_nxt_s    = state_r;
    lock_idx_nxt_s = lock_idx_r;
    rr_ptr_nxt_s   = rr_ptr_r;
    case (state_r)
      IDLE: begin
        if (xfer_s && !eom_s) begin
          state_nxt_s    = LOCKED;
          lock_idx_nxt_s = win_idx_s;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOCKED: begin
        if (xfer_s && eom_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = LOCKED;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
    if (xfer_s && eom_s && !mode) begin
      rr_ptr_nxt_s = (win_idx_s == IW'(N - 1)) ? '0 : win_idx_s + IW'(1);
    end else begin
      rr_ptr_nxt_s = rr_ptr_r;
    end
  end

  // Outputs: grant is forced low in reset so nothing leaks while nreset is asserted
  always_comb begin
    grant           = (nreset && win_vld_s) ? (N'(1'b1) << win_idx_s) : '0;
    umi_out_valid   = |(grant & umi_in_valid);
    umi_in_ready    = grant & {N{umi_out_ready}};
    umi_out_cmd     = umi_in_cmd[int'(win_idx_s) * CW +: CW];
    umi_out_dstaddr = umi_in_dstaddr[int'(win_idx_s) * AW +: AW];
    umi_out_srcaddr = umi_in_srcaddr[int'(win_idx_s) * AW +: AW];
    umi_out_data    = umi_in_data[int'(win_idx_s) * DW +: DW];
    locked          = (state_r == LOCKED);
    xfer_s          = umi_out_valid & umi_out_ready;
    eom_s           = umi_out_cmd[22];
  end

endmodule

// File: tb/tb_umi_req_arbiter.sv
// Directed self-checking bench for umi_req_arbiter (N=4).
module tb_umi_req_arbiter;

  localparam int N  = 4;
  localparam int CW = 32;
  localparam int AW = 64;
  localparam int DW = 128;

  logic            clk = 1'b0;
  logic            nreset;
  logic            mode;
  logic [N-1:0]    mask;
  logic [N-1:0]    valid;
  logic [CW-1:0]   cmd_a [N];
  logic [AW-1:0]   dst_a [N];
  logic [AW-1:0]   src_a [N];
  logic [DW-1:0]   data_a [N];
  logic [N*CW-1:0] in_cmd;
  logic [N*AW-1:0] in_dst;
  logic [N*AW-1:0] in_src;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_ready;
  logic            out_valid;
  logic [CW-1:0]   out_cmd;
  logic [AW-1:0]   out_dst;
  logic [AW-1:0]   out_src;
  logic [DW-1:0]   out_data;
  logic            out_ready;
  logic [N-1:0]    grant;
  logic            locked;

  int checks = 0;
  int errors = 0;

  localparam logic [3:0] AT_V     [6] = '{4'b0011, 4'b0010, 4'b0011, 4'b0010, 4'b0011, 4'b0010};
  localparam int         AT_SEQ   [6] = '{10, 10, 11, 11, 12, 12};
  localparam logic       AT_EOM   [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  localparam logic [3:0] AT_GRANT [6] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
  localparam logic       AT_LOCK  [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam logic       AT_OV    [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  for (genvar gi = 0; gi < N; gi++) begin : g_flat
    assign in_cmd[gi*CW +: CW]  = cmd_a[gi];
    assign in_dst[gi*AW +: AW]  = dst_a[gi];
    assign in_src[gi*AW +: AW]  = src_a[gi];
    assign in_data[gi*DW +: DW] = data_a[gi];
  end

  umi_req_arbiter #(.N(N), .CW(CW), .AW(AW), .DW(DW)) dut (
    .clk            (clk),
    .nreset         (nreset),
    .mode           (mode),
    .mask           (mask),
    .umi_in_valid   (valid),
    .umi_in_cmd     (in_cmd),
    .umi_in_dstaddr (in_dst),
    .umi_in_srcaddr (in_src),
    .umi_in_data    (in_data),
    .umi_in_ready   (in_ready),
    .umi_out_valid  (out_valid),
    .umi_out_cmd    (out_cmd),
    .umi_out_dstaddr(out_dst),
    .umi_out_srcaddr(out_src),
    .umi_out_data   (out_data),
    .umi_out_ready  (out_ready),
    .grant          (grant),
    .locked         (locked)
  );

  always #5 clk = ~clk;

  task automatic set_req(input int i, input int seq, input logic eom);
    cmd_a[i]  = {4'(i), 5'd0, eom, 14'd0, 8'(seq)};
    dst_a[i]  = {32'(i), 32'(seq)};
    src_a[i]  = ~{32'(i), 32'(seq)};
    data_a[i] = {dst_a[i], src_a[i]};
  endtask

  task automatic do_reset();
    @(negedge clk);
    nreset = 1'b0;
    valid = 4'b0000; mode = 1'b0; mask = 4'b0000; out_ready = 1'b1;
    @(negedge clk);
    nreset = 1'b1;
  endtask

  task automatic test_reset();
    nreset = 1'b0; mode = 1'b0; mask = 4'b0000; valid = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, i, 1'b1);
    #2;
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got=%b exp=%b", grant, 4'b0000); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready got=%b exp=%b", in_ready, 4'b0000); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got=%b exp=0", locked); end
    @(negedge clk);
    nreset = 1'b1;
  endtask

  task automatic test_fairness();
    logic [3:0] exp_g;
    int w;
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 16 + i, 1'b1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      valid = 4'b1111;
      #1;
      w = c % N;
      exp_g = 4'b0001 << w;
      checks++; if (grant !== exp_g) begin errors++; $display("FAIL rr_grant c=%0d got=%b exp=%b", c, grant, exp_g); end
      checks++; if (in_ready !== exp_g) begin errors++; $display("FAIL rr_in_ready c=%0d got=%b exp=%b", c, in_ready, exp_g); end
      checks++;
      if ({out_valid, out_cmd, out_dst, out_src, out_data} !== {1'b1, cmd_a[w], dst_a[w], src_a[w], data_a[w]}) begin
        errors++; $display("FAIL rr_payload c=%0d got_cmd=%h exp_cmd=%h got_data=%h exp_data=%h", c, out_cmd, cmd_a[w], out_data, data_a[w]);
      end
    end
  endtask

  task automatic test_atomicity();
    do_reset();
    set_req(1, 20, 1'b1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      valid = AT_V[c];
      set_req(0, AT_SEQ[c], AT_EOM[c]);
      #1;
      checks++; if (grant !== AT_GRANT[c]) begin errors++; $display("FAIL atom_grant c=%0d got=%b exp=%b", c, grant, AT_GRANT[c]); end
      checks++; if (in_ready !== AT_GRANT[c]) begin errors++; $display("FAIL atom_in_ready c=%0d got=%b exp=%b", c, in_ready, AT_GRANT[c]); end
      checks++; if (locked !== AT_LOCK[c]) begin errors++; $display("FAIL atom_locked c=%0d got=%b exp=%b", c, locked, AT_LOCK[c]); end
      checks++; if (out_valid !== AT_OV[c]) begin errors++; $display("FAIL atom_out_valid c=%0d got=%b exp=%b", c, out_valid, AT_OV[c]); end
    end
  endtask

  task automatic test_back_pressure();
    do_reset();
    set_req(1, 1, 1'b1);
    set_req(2, 2, 1'b1);
    set_req(3, 3, 1'b1);
    @(negedge clk);
    valid = 4'b0010;
    #1;
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL bp_setup got=%b exp=%b", grant, 4'b0010); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      valid = 4'b1100; out_ready = 1'b0;
      #1;
      checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL bp_grant c=%0d got=%b exp=%b", c, grant, 4'b0100); end
      checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL bp_in_ready c=%0d got=%b exp=%b", c, in_ready, 4'b0000); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid c=%0d got=%b exp=1", c, out_valid); end
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL bp_release got=%b exp=%b", in_ready, 4'b0100); end
    @(negedge clk);
    #1;
    checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL bp_next got=%b exp=%b", grant, 4'b1000); end
  endtask

  task automatic test_fixed_mask();
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 32 + i, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      mode = 1'b1; mask = 4'b0001; valid = 4'b1111;
      #1;
      checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL fp_grant c=%0d got=%b exp=%b", c, grant, 4'b0010); end
    end
    @(negedge clk);
    set_req(1, 5, 1'b0);
    #1;
    checks++; if ({grant, locked} !== {4'b0010, 1'b0}) begin errors++; $display("FAIL fp_msg_start got=%b/%b exp=0010/0", grant, locked); end
    @(negedge clk);
    mask = 4'b0000; set_req(1, 6, 1'b0);
    #1;
    checks++; if ({grant, locked} !== {4'b0010, 1'b1}) begin errors++; $display("FAIL fp_unmask_mid got=%b/%b exp=0010/1", grant, locked); end
    @(negedge clk);
    mask = 4'b0010; set_req(1, 7, 1'b1);
    #1;
    checks++; if ({grant, locked} !== {4'b0010, 1'b1}) begin errors++; $display("FAIL fp_mask_locked got=%b/%b exp=0010/1", grant, locked); end
    @(negedge clk);
    mask = 4'b0000;
    #1;
    checks++; if ({grant, locked} !== {4'b0001, 1'b0}) begin errors++; $display("FAIL fp_after_msg got=%b/%b exp=0001/0", grant, locked); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_req(1, 1, 1'b1);
    @(negedge clk);
    valid = 4'b0010;
    @(negedge clk);
    valid = 4'b0100; set_req(2, 2, 1'b0);
    #1;
    checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL rm_grant got=%b exp=%b", grant, 4'b0100); end
    @(negedge clk);
    valid = 4'b1111;
    for (int i = 0; i < N; i++) if (i != 2) set_req(i, 40 + i, 1'b1);
    #1;
    checks++; if ({grant, locked} !== {4'b0100, 1'b1}) begin errors++; $display("FAIL rm_locked got=%b/%b exp=0100/1", grant, locked); end
    #1;
    nreset = 1'b0;
    #1;
    checks++; if ({grant, locked, out_valid, in_ready} !== {4'b0000, 1'b0, 1'b0, 4'b0000}) begin
      errors++; $display("FAIL rm_in_reset grant=%b locked=%b out_valid=%b in_ready=%b exp all zero", grant, locked, out_valid, in_ready);
    end
    @(negedge clk);
    nreset = 1'b1;
    set_req(2, 3, 1'b1);
    #1;
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL rm_after_reset got=%b exp=%b", grant, 4'b0001); end
  endtask

  task automatic test_payload();
    int rem [N];
    int seq [N];
    int beat [N];
    int len;
    int owner;
    int w;
    int cyc;
    logic done;
    do_reset();
    for (int i = 0; i < N; i++) begin rem[i] = 3; seq[i] = 100 * i; beat[i] = 0; end
    owner = -1;
    cyc = 0;
    done = 1'b0;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < N; i++) begin
        len = i + 1;
        valid[i] = (rem[i] > 0);
        set_req(i, seq[i], beat[i] == len - 1);
      end
      out_ready = 1'($urandom_range(0, 1));
      #1;
      checks++; if (!$onehot0(in_ready)) begin errors++; $display("FAIL pl_ready_onehot cyc=%0d got=%b exp=at most one bit", cyc, in_ready); end
      checks++;
      if ((|(in_ready & valid)) !== (out_valid & out_ready)) begin
        errors++; $display("FAIL pl_handshake cyc=%0d in_hs=%b out_hs=%b", cyc, |(in_ready & valid), out_valid & out_ready);
      end
      if (out_valid && out_ready) begin
        w = -1;
        for (int i = 0; i < N; i++) if (in_ready[i] && valid[i]) w = i;
        checks++;
        if (w < 0) begin
          errors++; $display("FAIL pl_no_source cyc=%0d in_ready=%b valid=%b", cyc, in_ready, valid);
        end else begin
          if (owner >= 0 && w != owner) begin
            errors++; $display("FAIL pl_interleave cyc=%0d got=%0d exp=%0d", cyc, w, owner);
          end
          checks++;
          if ({out_cmd, out_dst, out_src, out_data} !== {cmd_a[w], dst_a[w], src_a[w], data_a[w]}) begin
            errors++; $display("FAIL pl_payload cyc=%0d req=%0d got_cmd=%h exp_cmd=%h got_dst=%h exp_dst=%h", cyc, w, out_cmd, cmd_a[w], out_dst, dst_a[w]);
          end
          seq[w]++;
          if (beat[w] == w) begin
            beat[w] = 0; rem[w]--; owner = -1;
          end else begin
            beat[w]++; owner = w;
          end
        end
      end
      done = 1'b1;
      for (int i = 0; i < N; i++) if (rem[i] != 0) done = 1'b0;
    end
    @(negedge clk);
    valid = 4'b0000;
    checks++;
    if (!done) begin
      errors++; $display("FAIL pl_timeout remaining=%0d/%0d/%0d/%0d exp=0/0/0/0", rem[0], rem[1], rem[2], rem[3]);
    end
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_atomicity();
    test_back_pressure();
    test_fixed_mask();
    test_reset_mid();
    test_payload();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
